// File: rtl/pll_lock_monitor.sv
// Measures the REF period in PLL-output clock cycles and derives a lock
// indication with hysteresis from runs of good and bad measurement windows.
module pll_lock_monitor #(
  parameter int CNT_W    = 16,
  parameter int EXP_CNT  = 8,
  parameter int TOL      = 1,
  parameter int LOCK_N   = 4,
  parameter int UNLOCK_N = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             REF,
  output logic [CNT_W-1:0] period,
  output logic             period_valid,
  output logic             in_range,
  output logic             locked,
  output logic             lock_lost,
  output logic             ref_timeout
);

  localparam int GOOD_W = $clog2(LOCK_N + 1);
  localparam int BAD_W  = $clog2(UNLOCK_N + 1);
  localparam int LO_INT = (EXP_CNT > TOL) ? (EXP_CNT - TOL) : 0;
  localparam int HI_INT = EXP_CNT + TOL;

  localparam logic [CNT_W-1:0]  CNT_LAST  = {{(CNT_W-1){1'b1}}, 1'b0};
  localparam logic [CNT_W:0]    LO_LIM    = (CNT_W+1)'(LO_INT);
  localparam logic [CNT_W:0]    HI_LIM    = (CNT_W+1)'(HI_INT);
  localparam logic [GOOD_W-1:0] GOOD_LAST = GOOD_W'(LOCK_N - 1);
  localparam logic [BAD_W-1:0]  BAD_LAST  = BAD_W'(UNLOCK_N - 1);

  typedef enum logic [1:0] {
    ST_OFF       = 2'd0,
    ST_WAIT_EDGE = 2'd1,
    ST_MEASURE   = 2'd2,
    ST_LOCKED    = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic              ref_s1_q, ref_s1_d;
  logic              ref_s2_q, ref_s2_d;
  logic              ref_s3_q, ref_s3_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [GOOD_W-1:0] good_cnt_q, good_cnt_d;
  logic [BAD_W-1:0]  bad_cnt_q, bad_cnt_d;
  logic [CNT_W-1:0]  period_q, period_d;
  logic              period_valid_q, period_valid_d;
  logic              in_range_q, in_range_d;
  logic              locked_q, locked_d;
  logic              lock_lost_q, lock_lost_d;
  logic              ref_timeout_q, ref_timeout_d;

  logic              rise;
  logic [CNT_W:0]    meas_len;
  logic              range_ok;
  logic              win_close;
  logic              win_good;

  assign rise     = ref_s2_q & ~ref_s3_q;
  // One extra bit so the upper limit compare cannot wrap.
  assign meas_len = {1'b0, cnt_q} + (CNT_W+1)'(1);
  assign range_ok = (meas_len >= LO_LIM) && (meas_len <= HI_LIM);

  always_comb begin
    ref_s1_d       = REF;
    ref_s2_d       = ref_s1_q;
    ref_s3_d       = ref_s2_q;
    state_d        = state_q;
    cnt_d          = cnt_q;
    good_cnt_d     = good_cnt_q;
    bad_cnt_d      = bad_cnt_q;
    period_d       = period_q;
    in_range_d     = in_range_q;
    period_valid_d = 1'b0;
    ref_timeout_d  = 1'b0;
    lock_lost_d    = lock_lost_q;
    locked_d       = (state_q == ST_LOCKED);
    win_close      = 1'b0;
    win_good       = 1'b0;

    if (!en) begin
      state_d    = ST_OFF;
      cnt_d      = '0;
      good_cnt_d = '0;
      bad_cnt_d  = '0;
      locked_d   = 1'b0;
    end else if (state_q == ST_OFF) begin
      state_d = ST_WAIT_EDGE;
    end else begin
      // A rise beats a coincident timeout; a timeout is a forced bad window.
      if (rise) begin
        cnt_d     = '0;
        win_close = (state_q != ST_WAIT_EDGE);
        win_good  = range_ok;
      end else if (cnt_q == CNT_LAST) begin
        cnt_d         = '0;
        ref_timeout_d = 1'b1;
        win_close     = (state_q != ST_WAIT_EDGE);
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end

      if (win_close) begin
        period_valid_d = 1'b1;
        period_d       = meas_len[CNT_W-1:0];
        in_range_d     = win_good;
      end

      case (state_q)
        ST_WAIT_EDGE: begin
          if (rise) begin
            state_d    = ST_MEASURE;
            good_cnt_d = '0;
            bad_cnt_d  = '0;
          end
        end
        ST_MEASURE: begin
          if (win_close) begin
            if (!win_good) begin
              good_cnt_d = '0;
            end else if (good_cnt_q == GOOD_LAST) begin
              state_d    = ST_LOCKED;
              good_cnt_d = '0;
              bad_cnt_d  = '0;
            end else begin
              good_cnt_d = good_cnt_q + GOOD_W'(1);
            end
          end
        end
        ST_LOCKED: begin
          if (win_close) begin
            if (win_good) begin
              bad_cnt_d = '0;
            end else if (bad_cnt_q == BAD_LAST) begin
              state_d     = ST_MEASURE;
              lock_lost_d = 1'b1;
              good_cnt_d  = '0;
              bad_cnt_d   = '0;
            end else begin
              bad_cnt_d = bad_cnt_q + BAD_W'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= ST_OFF;
      ref_s1_q       <= 1'b0;
      ref_s2_q       <= 1'b0;
      ref_s3_q       <= 1'b0;
      cnt_q          <= '0;
      good_cnt_q     <= '0;
      bad_cnt_q      <= '0;
      period_q       <= '0;
      period_valid_q <= 1'b0;
      in_range_q     <= 1'b0;
      locked_q       <= 1'b0;
      lock_lost_q    <= 1'b0;
      ref_timeout_q  <= 1'b0;
    end else begin
      state_q        <= state_d;
      ref_s1_q       <= ref_s1_d;
      ref_s2_q       <= ref_s2_d;
      ref_s3_q       <= ref_s3_d;
      cnt_q          <= cnt_d;
      good_cnt_q     <= good_cnt_d;
      bad_cnt_q      <= bad_cnt_d;
      period_q       <= period_d;
      period_valid_q <= period_valid_d;
      in_range_q     <= in_range_d;
      locked_q       <= locked_d;
      lock_lost_q    <= lock_lost_d;
      ref_timeout_q  <= ref_timeout_d;
    end
  end

  assign period       = period_q;
  assign period_valid = period_valid_q;
  assign in_range     = in_range_q;
  assign locked       = locked_q;
  assign lock_lost    = lock_lost_q;
  assign ref_timeout  = ref_timeout_q;

endmodule

// File: tb/tb_pll_lock_monitor.sv
// Bench for pll_lock_monitor: directed window table, hand-written corner
// sequences and random REF periods against a window-level lock model.
module tb_pll_lock_monitor;
  localparam int CNT_W    = 8;
  localparam int EXP_CNT  = 8;
  localparam int TOL      = 1;
  localparam int LOCK_N   = 4;
  localparam int UNLOCK_N = 2;
  localparam int TMO      = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             en = 1'b0;
  logic             REF = 1'b0;
  logic [CNT_W-1:0] period;
  logic             period_valid, in_range, locked, lock_lost, ref_timeout;

  pll_lock_monitor #(
    .CNT_W(CNT_W), .EXP_CNT(EXP_CNT), .TOL(TOL), .LOCK_N(LOCK_N), .UNLOCK_N(UNLOCK_N)
  ) dut (
    .clk(clk), .reset(reset), .en(en), .REF(REF),
    .period(period), .period_valid(period_valid), .in_range(in_range),
    .locked(locked), .lock_lost(lock_lost), .ref_timeout(ref_timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    int ref_p;
    int exp_period;
    bit exp_in_range;
    bit exp_locked;
    bit exp_lost;
  } vec_t;

  typedef struct {
    int period;
    bit in_range;
    bit locked;
    bit lost;
  } win_t;

  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   n_win = 0;
  win_t exp_q[$];
  bit   pend_chk = 1'b0;
  win_t pend_w;
  win_t mon_w;
  bit   timeout_ok = 1'b0;
  int   n_tmo = 0;
  int   last_tmo_cyc = 0;
  vec_t tbl[14];

  // Window-level lock model state
  bit m_locked;
  bit m_lost;
  int m_good;
  int m_bad;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (pend_chk) begin
      check("locked_after_window", {31'd0, locked}, {31'd0, pend_w.locked});
      check("lock_lost_after_window", {31'd0, lock_lost}, {31'd0, pend_w.lost});
      pend_chk = 1'b0;
    end
    if (ref_timeout === 1'b1) begin
      n_tmo++;
      last_tmo_cyc = cyc;
    end
    if (!timeout_ok && ref_timeout !== 1'b0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL unexpected_timeout: ref_timeout=%b, expected 0 (cycle %0d)", ref_timeout, cyc);
    end
    if (period_valid !== 1'b0) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_window: period_valid=%b period=%0d, expected no window", period_valid, period);
      end else begin
        mon_w = exp_q.pop_front();
        n_win++;
        $display("window %0d: period=%0d in_range=%b (expect %0d/%0b)", n_win, period, in_range,
                 mon_w.period, mon_w.in_range);
        check("period", {24'd0, period}, mon_w.period);
        check("in_range", {31'd0, in_range}, {31'd0, mon_w.in_range});
        pend_w   = mon_w;
        pend_chk = 1'b1;
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic model_clear(input bit full);
    m_locked = 1'b0;
    m_good   = 0;
    m_bad    = 0;
    if (full) m_lost = 1'b0;
  endtask

  // Lock rule expressed as run lengths of good/bad windows
  task automatic model_window(input int p, input bit tmo, output win_t w);
    int d;
    bit good;
    d    = p - EXP_CNT;
    good = !tmo && (d <= TOL) && (d >= -TOL);
    if (!m_locked) begin
      m_good = good ? m_good + 1 : 0;
      if (m_good >= LOCK_N) begin
        m_locked = 1'b1;
        m_bad    = 0;
      end
    end else begin
      m_bad = good ? 0 : m_bad + 1;
      if (m_bad >= UNLOCK_N) begin
        m_locked = 1'b0;
        m_lost   = 1'b1;
        m_good   = 0;
      end
    end
    w.period   = p;
    w.in_range = good;
    w.locked   = m_locked;
    w.lost     = m_lost;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    step(2);
    reset = 1'b0;
    model_clear(1'b1);
  endtask

  task automatic start_monitor();
    en = 1'b1;
    step(3);
  endtask

  task automatic ref_period(input int p);
    REF = 1'b1;
    step(p / 2);
    REF = 1'b0;
    step(p - p / 2);
  endtask

  task automatic drive_window(input int p);
    win_t w;
    model_window(p, 1'b0, w);
    exp_q.push_back(w);
    ref_period(p);
  endtask

  task automatic close_and_drain();
    REF = 1'b1;
    step(3);
    REF = 1'b0;
    step(6);
    check("windows_drained", exp_q.size(), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    win_t w;
    int   t1;
    int   r;

    //               ref_p period in_range locked lost
    tbl[0]  = '{8,  8,  1'b1, 1'b0, 1'b0};
    tbl[1]  = '{8,  8,  1'b1, 1'b0, 1'b0};
    tbl[2]  = '{6,  6,  1'b0, 1'b0, 1'b0};
    tbl[3]  = '{7,  7,  1'b1, 1'b0, 1'b0};
    tbl[4]  = '{9,  9,  1'b1, 1'b0, 1'b0};
    tbl[5]  = '{8,  8,  1'b1, 1'b0, 1'b0};
    tbl[6]  = '{8,  8,  1'b1, 1'b1, 1'b0};
    tbl[7]  = '{11, 11, 1'b0, 1'b1, 1'b0};
    tbl[8]  = '{8,  8,  1'b1, 1'b1, 1'b0};
    tbl[9]  = '{10, 10, 1'b0, 1'b1, 1'b0};
    tbl[10] = '{8,  8,  1'b1, 1'b1, 1'b0};
    tbl[11] = '{10, 10, 1'b0, 1'b1, 1'b0};
    tbl[12] = '{10, 10, 1'b0, 1'b0, 1'b1};
    tbl[13] = '{8,  8,  1'b1, 1'b0, 1'b1};

    // Reset state
    apply_reset();
    @(negedge clk);
    check("rst_period", {24'd0, period}, 0);
    check("rst_period_valid", {31'd0, period_valid}, 0);
    check("rst_in_range", {31'd0, in_range}, 0);
    check("rst_locked", {31'd0, locked}, 0);
    check("rst_lock_lost", {31'd0, lock_lost}, 0);
    check("rst_ref_timeout", {31'd0, ref_timeout}, 0);
    @(posedge clk);
    #1;

    // Directed window table: lock, boundaries, single bad, unlock
    start_monitor();
    for (int i = 0; i < 14; i++) begin
      w = '{tbl[i].exp_period, tbl[i].exp_in_range, tbl[i].exp_locked, tbl[i].exp_lost};
      exp_q.push_back(w);
      ref_period(tbl[i].ref_p);
    end
    close_and_drain();

    // REF stuck low: timeouts in WAIT_EDGE, then as bad windows when locked
    apply_reset();
    timeout_ok = 1'b1;
    n_tmo = 0;
    start_monitor();
    for (int i = 0; i < 600 && n_tmo < 1; i++) step(1);
    check("tmo_first_seen", n_tmo, 1);
    t1 = last_tmo_cyc;
    for (int i = 0; i < 600 && n_tmo < 2; i++) step(1);
    check("tmo_second_seen", n_tmo, 2);
    check("tmo_gap", last_tmo_cyc - t1, TMO);
    check("wait_edge_locked", {31'd0, locked}, 0);
    check("wait_edge_period", {24'd0, period}, 0);
    en = 1'b0;
    step(2);
    model_clear(1'b0);
    start_monitor();
    for (int i = 0; i < 4; i++) drive_window(8);
    n_tmo = 0;
    REF = 1'b1;
    step(3);
    REF = 1'b0;
    for (int i = 0; i < 2; i++) begin
      model_window(TMO, 1'b1, w);
      exp_q.push_back(w);
    end
    step(2 * TMO + 20);
    check("tmo_locked_count", n_tmo, 2);
    check("tmo_windows_drained", exp_q.size(), 0);
    en = 1'b0;
    step(2);
    timeout_ok = 1'b0;

    // en dropped while locked
    apply_reset();
    start_monitor();
    for (int i = 0; i < 5; i++) drive_window(8);
    close_and_drain();
    check("locked_before_disable", {31'd0, locked}, 1);
    en = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("disable_locked", {31'd0, locked}, 0);
    check("disable_lock_lost", {31'd0, lock_lost}, 0);
    check("disable_period_held", {24'd0, period}, 8);
    @(posedge clk);
    #1;
    model_clear(1'b0);
    start_monitor();
    for (int i = 0; i < 4; i++) drive_window(8);
    close_and_drain();

    // Reset mid-MEASURE after three good windows
    apply_reset();
    start_monitor();
    for (int i = 0; i < 3; i++) drive_window(8);
    close_and_drain();
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("midrst_period", {24'd0, period}, 0);
    check("midrst_in_range", {31'd0, in_range}, 0);
    check("midrst_locked", {31'd0, locked}, 0);
    check("midrst_period_valid", {31'd0, period_valid}, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_clear(1'b1);
    step(3);
    for (int i = 0; i < 4; i++) drive_window(8);
    close_and_drain();

    // Random REF periods around the expected ratio
    apply_reset();
    start_monitor();
    for (int i = 0; i < 40; i++) begin
      r = int'($urandom_range(0, 9));
      if (r < 7) drive_window(7 + (r % 3));
      else if (r == 7) drive_window(6);
      else if (r == 8) drive_window(10);
      else drive_window(11);
    end
    close_and_drain();
    en = 1'b0;
    step(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
